// File: rtl/regfile_ctrl_pkg.sv
// Shared types for the register-file writeback arbiter: widths, source encoding,
// buffered entry record and the wrap-safe sequence age compare.
package regfile_ctrl_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int SEQ_WIDTH  = 4;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [SEQ_WIDTH-1:0]  seq;
  } wbEntry_t;

  // a is older than b when (b - a) mod 2^SEQ_WIDTH is nonzero with a clear MSB
  function automatic logic isOlder(input logic [SEQ_WIDTH-1:0] a,
                                   input logic [SEQ_WIDTH-1:0] b);
    logic [SEQ_WIDTH-1:0] diff;
    diff = b - a;
    return (diff != '0) && !diff[SEQ_WIDTH-1];
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous entry FIFO for one writeback source; exposes the head plus a
// per-slot valid/address view so the top can match in-flight destinations.
module wb_fifo
  import regfile_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                           iClk,
  input  logic                           iRst,
  input  logic                           iPush,
  input  wbEntry_t                       iPushEntry,
  input  logic                           iPop,
  output wbEntry_t                       oHead,
  output logic                           oFull,
  output logic                           oEmpty,
  output logic [FIFO_DEPTH-1:0]          oValidVec,
  output logic [FIFO_DEPTH*ADDR_WIDTH-1:0] oAddrVec
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  wbEntry_t         entryMem [FIFO_DEPTH];
  logic [PTR_W-1:0] rdPtrReg;
  logic [PTR_W-1:0] wrPtrReg;
  logic [PTR_W:0]   countReg;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rdPtrReg <= '0;
      wrPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (iPush) wrPtrReg <= wrPtrReg + 1'b1;
      if (iPop)  rdPtrReg <= rdPtrReg + 1'b1;
      case ({iPush, iPop})
        2'b10:   countReg <= countReg + 1'b1;
        2'b01:   countReg <= countReg - 1'b1;
        default: countReg <= countReg;
      endcase
    end
  end

  // Storage carries no reset: occupancy alone decides which slots are live.
  always_ff @(posedge iClk) begin
    if (iPush) entryMem[wrPtrReg] <= iPushEntry;
  end

  assign oHead  = entryMem[rdPtrReg];
  assign oFull  = (countReg == (PTR_W+1)'(FIFO_DEPTH));
  assign oEmpty = (countReg == '0);

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : gSlot
      wire [PTR_W-1:0] slotOffset = PTR_W'(gi) - rdPtrReg;
      assign oValidVec[gi] = ({1'b0, slotOffset} < countReg);
      assign oAddrVec[gi*ADDR_WIDTH +: ADDR_WIDTH] = entryMem[gi].addr;
    end
  endgenerate

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writebacks with
// per-source buffering, same-register ordering, MEM priority and bounded ALU starvation.
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iAluValid,
  output logic                  oAluReady,
  input  logic [ADDR_WIDTH-1:0] iAluAddr,
  input  logic [DATA_WIDTH-1:0] iAluData,
  input  logic                  iMemValid,
  output logic                  oMemReady,
  input  logic [ADDR_WIDTH-1:0] iMemAddr,
  input  logic [DATA_WIDTH-1:0] iMemData,
  output logic                  oWrEn,
  output logic [ADDR_WIDTH-1:0] oWrAddr,
  output logic [DATA_WIDTH-1:0] oWrData,
  input  logic [ADDR_WIDTH-1:0] iQueryAddr0,
  input  logic [ADDR_WIDTH-1:0] iQueryAddr1,
  output logic                  oPending0,
  output logic                  oPending1,
  output logic                  oBusy
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic                           aluFull, aluEmpty, memFull, memEmpty;
  logic                           aluPush, memPush, aluPop, memPop;
  wbEntry_t                       aluHead, memHead, aluPushEntry, memPushEntry, grantEntry;
  logic [FIFO_DEPTH-1:0]          aluValidVec, memValidVec;
  logic [FIFO_DEPTH*ADDR_WIDTH-1:0] aluAddrVec, memAddrVec;
  logic [SEQ_WIDTH-1:0]           seqReg, aluTag;
  logic [STARVE_W-1:0]            starveReg;
  logic                           grantValid, grantSrc;
  logic                           wrEnReg;
  logic [ADDR_WIDTH-1:0]          wrAddrReg;
  logic [DATA_WIDTH-1:0]          wrDataReg;

  assign oAluReady = !aluFull;
  assign oMemReady = !memFull;
  assign aluPush   = iAluValid && oAluReady;
  assign memPush   = iMemValid && oMemReady;

  // A simultaneous load is treated as older, so it takes the lower tag.
  assign aluTag       = memPush ? seqReg + 1'b1 : seqReg;
  assign memPushEntry = '{addr: iMemAddr, data: iMemData, seq: seqReg};
  assign aluPushEntry = '{addr: iAluAddr, data: iAluData, seq: aluTag};

  wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) uAluFifo (
    .iClk(iClk), .iRst(iRst), .iPush(aluPush), .iPushEntry(aluPushEntry), .iPop(aluPop),
    .oHead(aluHead), .oFull(aluFull), .oEmpty(aluEmpty),
    .oValidVec(aluValidVec), .oAddrVec(aluAddrVec)
  );

  wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) uMemFifo (
    .iClk(iClk), .iRst(iRst), .iPush(memPush), .iPushEntry(memPushEntry), .iPop(memPop),
    .oHead(memHead), .oFull(memFull), .oEmpty(memEmpty),
    .oValidVec(memValidVec), .oAddrVec(memAddrVec)
  );

  always_comb begin
    grantValid = 1'b0;
    grantSrc   = SRC_MEM;
    if (!aluEmpty && memEmpty) begin
      grantValid = 1'b1;
      grantSrc   = SRC_ALU;
    end else if (aluEmpty && !memEmpty) begin
      grantValid = 1'b1;
      grantSrc   = SRC_MEM;
    end else if (!aluEmpty && !memEmpty) begin
      grantValid = 1'b1;
      if (aluHead.addr == memHead.addr)
        grantSrc = isOlder(aluHead.seq, memHead.seq) ? SRC_ALU : SRC_MEM;
      else if (starveReg == STARVE_W'(STARVE_LIMIT))
        grantSrc = SRC_ALU;
      else
        grantSrc = SRC_MEM;
    end
  end

  assign aluPop     = grantValid && (grantSrc == SRC_ALU);
  assign memPop     = grantValid && (grantSrc == SRC_MEM);
  assign grantEntry = (grantSrc == SRC_ALU) ? aluHead : memHead;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      seqReg    <= '0;
      starveReg <= '0;
      wrEnReg   <= 1'b0;
      wrAddrReg <= '0;
      wrDataReg <= '0;
    end else begin
      seqReg <= seqReg + SEQ_WIDTH'(aluPush) + SEQ_WIDTH'(memPush);
      if (aluEmpty || aluPop)
        starveReg <= '0;
      else if (starveReg != STARVE_W'(STARVE_LIMIT))
        starveReg <= starveReg + 1'b1;
      wrEnReg <= grantValid && (grantEntry.addr != '0);
      if (grantValid) begin
        wrAddrReg <= grantEntry.addr;
        wrDataReg <= grantEntry.data;
      end
    end
  end

  assign oWrEn   = wrEnReg;
  assign oWrAddr = wrAddrReg;
  assign oWrData = wrDataReg;

  logic [FIFO_DEPTH-1:0] aluHit0, aluHit1, memHit0, memHit1;

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : gHit
      assign aluHit0[gi] = aluValidVec[gi] && (aluAddrVec[gi*ADDR_WIDTH +: ADDR_WIDTH] == iQueryAddr0);
      assign aluHit1[gi] = aluValidVec[gi] && (aluAddrVec[gi*ADDR_WIDTH +: ADDR_WIDTH] == iQueryAddr1);
      assign memHit0[gi] = memValidVec[gi] && (memAddrVec[gi*ADDR_WIDTH +: ADDR_WIDTH] == iQueryAddr0);
      assign memHit1[gi] = memValidVec[gi] && (memAddrVec[gi*ADDR_WIDTH +: ADDR_WIDTH] == iQueryAddr1);
    end
  endgenerate

  // The output-register term covers the write that lands on the next edge.
  assign oPending0 = (iQueryAddr0 != '0) &&
                     ((|aluHit0) || (|memHit0) || (wrEnReg && (wrAddrReg == iQueryAddr0)));
  assign oPending1 = (iQueryAddr1 != '0) &&
                     ((|aluHit1) || (|memHit1) || (wrEnReg && (wrAddrReg == iQueryAddr1)));

  assign oBusy = !aluEmpty || !memEmpty || wrEnReg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed checks of regfile_wb_arbiter against a queue-based
// reference model using unbounded sequence numbers for age.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 3;

  logic        iClk = 1'b0;
  logic        iRst = 1'b0;
  logic        iAluValid = 1'b0, iMemValid = 1'b0;
  logic [4:0]  iAluAddr = '0, iMemAddr = '0, iQueryAddr0 = '0, iQueryAddr1 = '0;
  logic [31:0] iAluData = '0, iMemData = '0;
  logic        oAluReady, oMemReady, oWrEn, oPending0, oPending1, oBusy;
  logic [4:0]  oWrAddr;
  logic [31:0] oWrData;

  regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .iClk(iClk), .iRst(iRst),
    .iAluValid(iAluValid), .oAluReady(oAluReady), .iAluAddr(iAluAddr), .iAluData(iAluData),
    .iMemValid(iMemValid), .oMemReady(oMemReady), .iMemAddr(iMemAddr), .iMemData(iMemData),
    .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData),
    .iQueryAddr0(iQueryAddr0), .iQueryAddr1(iQueryAddr1),
    .oPending0(oPending0), .oPending1(oPending1), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          seq;
  } mEnt_t;

  mEnt_t       aluQ[$], memQ[$];
  int          seqCnt, starve, mWrAddr;
  bit          mWrEn, modelInit;
  logic [31:0] mWrData;
  int          checks, failures, obsWr, accNz;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit expPend(input int q);
    if (q == 0) return 1'b0;
    foreach (aluQ[i]) if (aluQ[i].addr == q) return 1'b1;
    foreach (memQ[i]) if (memQ[i].addr == q) return 1'b1;
    return mWrEn && (mWrAddr == q);
  endfunction

  // One clock: drive inputs at the falling edge, check the model, advance both.
  task automatic cycle(input bit rst, input bit aV, input int aA, input logic [31:0] aD,
                       input bit mV, input int mA, input logic [31:0] mD, input int q0);
    int    q1, g;
    bit    accA, accM;
    mEnt_t e;
    q1 = $urandom_range(0, 7);
    iRst = rst; iAluValid = aV; iAluAddr = aA[4:0]; iAluData = aD;
    iMemValid = mV; iMemAddr = mA[4:0]; iMemData = mD;
    iQueryAddr0 = q0[4:0]; iQueryAddr1 = q1[4:0];
    #1;
    if (oWrEn === 1'b1) obsWr++;
    if (modelInit) begin
      checkVal("alu_ready", oAluReady, aluQ.size() < DEPTH);
      checkVal("mem_ready", oMemReady, memQ.size() < DEPTH);
      checkVal("wr_en", oWrEn, mWrEn);
      checkVal("wr_addr", oWrAddr, mWrAddr);
      checkVal("wr_data", oWrData, mWrData);
      checkVal("busy", oBusy, (aluQ.size() > 0) || (memQ.size() > 0) || mWrEn);
      checkVal("pending0", oPending0, expPend(q0));
      checkVal("pending1", oPending1, expPend(q1));
    end
    if (rst) begin
      aluQ.delete(); memQ.delete();
      seqCnt = 0; starve = 0; mWrEn = 0; mWrAddr = 0; mWrData = '0;
      modelInit = 1;
    end else if (modelInit) begin
      accA = aV && (aluQ.size() < DEPTH);
      accM = mV && (memQ.size() < DEPTH);
      g = 0;
      if (aluQ.size() > 0 && memQ.size() == 0) g = 1;
      else if (memQ.size() > 0 && aluQ.size() == 0) g = 2;
      else if (aluQ.size() > 0 && memQ.size() > 0) begin
        if (aluQ[0].addr == memQ[0].addr) g = (aluQ[0].seq < memQ[0].seq) ? 1 : 2;
        else g = (starve == LIMIT) ? 1 : 2;
      end
      if (aluQ.size() == 0 || g == 1) starve = 0;
      else if (starve < LIMIT) starve++;
      if (g != 0) begin
        e = (g == 1) ? aluQ.pop_front() : memQ.pop_front();
        mWrEn = (e.addr != 0); mWrAddr = e.addr; mWrData = e.data;
      end else begin
        mWrEn = 0;
      end
      if (accM) begin
        memQ.push_back('{addr: mA, data: mD, seq: seqCnt});
        if (mA != 0) accNz++;
      end
      if (accA) begin
        aluQ.push_back('{addr: aA, data: aD, seq: seqCnt + int'(accM)});
        if (aA != 0) accNz++;
      end
      seqCnt += int'(accM) + int'(accA);
    end
    @(posedge iClk);
    @(negedge iClk);
  endtask

  task automatic idle(input int n, input int q0);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, 0, 0, '0, q0);
  endtask

  initial begin
    int startWr, startAcc, grantCycle;
    checks = 0; failures = 0; obsWr = 0; accNz = 0; modelInit = 0;
    @(negedge iClk);
    cycle(1, 0, 0, '0, 0, 0, '0, 0);
    checkVal("rst_wr_en", oWrEn, 0);
    checkVal("rst_wr_addr", oWrAddr, 0);
    checkVal("rst_wr_data", oWrData, 0);
    checkVal("rst_alu_ready", oAluReady, 1);
    checkVal("rst_mem_ready", oMemReady, 1);

    // Single ALU write: visible only in the cycle after the second edge.
    cycle(0, 1, 5, 32'hDEADBEEF, 0, 0, '0, 5);
    checkVal("single_n_wr_en", oWrEn, 0);
    checkVal("single_n_pend", oPending0, 1);
    idle(1, 5);
    checkVal("single_n1_wr_en", oWrEn, 1);
    checkVal("single_n1_addr", oWrAddr, 5);
    checkVal("single_n1_data", oWrData, 32'hDEADBEEF);
    checkVal("single_n1_pend", oPending0, 1);
    idle(1, 5);
    checkVal("single_n2_wr_en", oWrEn, 0);
    checkVal("single_n2_pend", oPending0, 0);

    // Register 0 is consumed silently.
    idle(2, 0);
    cycle(0, 1, 0, 32'h1234, 0, 0, '0, 0);
    checkVal("r0_pend", oPending0, 0);
    checkVal("r0_busy", oBusy, 1);
    idle(1, 0);
    checkVal("r0_wr_en", oWrEn, 0);
    idle(1, 0);
    checkVal("r0_idle", oBusy, 0);

    // Same destination in the same cycle: load first, then ALU.
    cycle(0, 1, 7, 32'h2, 1, 7, 32'h1, 7);
    idle(1, 7);
    checkVal("order_first_en", oWrEn, 1);
    checkVal("order_first_data", oWrData, 32'h1);
    idle(1, 7);
    checkVal("order_second_en", oWrEn, 1);
    checkVal("order_second_data", oWrData, 32'h2);
    idle(2, 0);

    // Starvation bound with a continuous stream of loads to distinct registers.
    grantCycle = 0;
    cycle(0, 1, 3, 32'hA1, 1, 9, 32'hB0, 3);
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 0, '0, 1, 9 + i, 32'hB0 + i, 3);
      if (grantCycle == 0 && oWrEn && oWrAddr == 5'd3) grantCycle = i;
    end
    checkVal("starve_grant_cycle", grantCycle, LIMIT + 1);
    idle(4, 0);

    // Reset in the middle of traffic discards everything buffered.
    for (int i = 0; i < 3; i++) cycle(0, 1, 10 + i, 32'hC0 + i, 1, 20 + i, 32'hD0 + i, 0);
    cycle(1, 1, 11, 32'hEE, 1, 21, 32'hEF, 0);
    checkVal("midrst_wr_en", oWrEn, 0);
    checkVal("midrst_busy", oBusy, 0);
    checkVal("midrst_alu_ready", oAluReady, 1);
    checkVal("midrst_mem_ready", oMemReady, 1);
    startWr = obsWr;
    idle(4, 0);
    checkVal("midrst_no_writes", obsWr - startWr, 0);

    // Random backpressure traffic against the model plus a write-count scoreboard.
    startWr = obsWr; startAcc = accNz;
    for (int i = 0; i < 200; i++) begin
      cycle(0, ($urandom % 4) != 0, $urandom_range(0, 7), $urandom,
               ($urandom % 4) != 0, $urandom_range(0, 7), $urandom, $urandom_range(0, 7));
    end
    idle(8, 0);
    checkVal("rand_write_count", obsWr - startWr, accNz - startAcc);
    checkVal("rand_drained", oBusy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
